// File: rtl/e_mdu_ctrl.sv
// Purpose: E-stage multiply/divide sequencer owning HI/LO; serves mfhi/mflo/mthi/mtlo.
// Latency: mult/multu retire MULT_CYCLES edges after start, div/divu DIV_CYCLES; mt*/mf* single cycle.
// Backpressure: no handshake; busy/md_stall tell the hazard unit to hold md-type ops in D.
module e_mdu_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  mdu_op,
  input  logic [31:0] SrcA,
  input  logic [31:0] SrcB,
  input  logic        D_is_md,
  output logic        busy,
  output logic        md_stall,
  output logic [31:0] MDUresult,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW = $clog2(MAX_CYCLES + 1);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MFHI  = 4'd5;
  localparam logic [3:0] OP_MFLO  = 4'd6;
  localparam logic [3:0] OP_MTHI  = 4'd7;
  localparam logic [3:0] OP_MTLO  = 4'd8;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t         state, state_nxt;
  logic [CW-1:0]  counter;
  logic [31:0]    temp_hi, temp_lo;
  // Cleared for divide-by-zero so completion leaves HI/LO untouched.
  logic           temp_wr;

  logic           launch;
  logic           last_cycle;
  logic [63:0]    prod_s, prod_u;
  logic [31:0]    calc_hi, calc_lo;
  logic           calc_wr;
  logic signed [31:0] sa, sb;

  assign launch     = (state == IDLE) && start &&
                      (mdu_op == OP_MULT || mdu_op == OP_MULTU ||
                       mdu_op == OP_DIV  || mdu_op == OP_DIVU);
  assign last_cycle = (state == BUSY) && (counter == CW'(1));
  assign sa         = SrcA;
  assign sb         = SrcB;
  // Low 64 bits of the sign-extended product equal the signed 32x32 product.
  assign prod_s     = {{32{SrcA[31]}}, SrcA} * {{32{SrcB[31]}}, SrcB};
  assign prod_u     = {32'b0, SrcA} * {32'b0, SrcB};

  // Result of the op being launched this cycle; divides are guarded so no
  // zero divisor or INT_MIN/-1 overflow ever reaches the divider.
  always_comb begin
    calc_hi = 32'b0;
    calc_lo = 32'b0;
    calc_wr = 1'b1;
    case (mdu_op)
      OP_MULT:  begin calc_hi = prod_s[63:32]; calc_lo = prod_s[31:0]; end
      OP_MULTU: begin calc_hi = prod_u[63:32]; calc_lo = prod_u[31:0]; end
      OP_DIV: begin
        if (SrcB == 32'b0) begin
          calc_wr = 1'b0;
        end else if (SrcA == 32'h8000_0000 && SrcB == 32'hFFFF_FFFF) begin
          calc_lo = 32'h8000_0000;
          calc_hi = 32'b0;
        end else begin
          calc_lo = sa / sb;
          calc_hi = sa % sb;
        end
      end
      OP_DIVU: begin
        if (SrcB == 32'b0) begin
          calc_wr = 1'b0;
        end else begin
          calc_lo = SrcA / SrcB;
          calc_hi = SrcA % SrcB;
        end
      end
      default: calc_wr = 1'b0;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state: launch moves to BUSY, final countdown edge returns to IDLE.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (launch) state_nxt = BUSY;
      BUSY:    if (last_cycle) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Countdown and operand-result capture at launch.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      counter <= '0;
      temp_hi <= 32'b0;
      temp_lo <= 32'b0;
      temp_wr <= 1'b0;
      busy    <= 1'b0;
    end else if (launch) begin
      counter <= (mdu_op == OP_MULT || mdu_op == OP_MULTU) ? CW'(MULT_CYCLES) : CW'(DIV_CYCLES);
      temp_hi <= calc_hi;
      temp_lo <= calc_lo;
      temp_wr <= calc_wr;
      busy    <= 1'b1;
    end else if (state == BUSY) begin
      counter <= counter - CW'(1);
      if (last_cycle) busy <= 1'b0;
    end
  end

  // HI/LO: retire on final busy edge; mthi/mtlo only honoured while idle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      HI <= 32'b0;
      LO <= 32'b0;
    end else if (last_cycle) begin
      if (temp_wr) begin
        HI <= temp_hi;
        LO <= temp_lo;
      end
    end else if (state == IDLE) begin
      if (mdu_op == OP_MTHI) HI <= SrcA;
      if (mdu_op == OP_MTLO) LO <= SrcA;
    end
  end

  // Combinational read port and hazard stall.
  always_comb begin
    MDUresult = 32'b0;
    if (mdu_op == OP_MFHI)      MDUresult = HI;
    else if (mdu_op == OP_MFLO) MDUresult = LO;
  end

  assign md_stall = D_is_md & (start | busy);

endmodule

// File: tb/tb_e_mdu_ctrl.sv
module tb_e_mdu_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [3:0]  mdu_op;
  logic [31:0] SrcA, SrcB;
  logic        D_is_md;
  logic        busy, md_stall;
  logic [31:0] MDUresult, HI, LO;

  int tests = 0;
  int fails = 0;
  int n;

  e_mdu_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .start(start), .mdu_op(mdu_op),
    .SrcA(SrcA), .SrcB(SrcB), .D_is_md(D_is_md), .busy(busy),
    .md_stall(md_stall), .MDUresult(MDUresult), .HI(HI), .LO(LO)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Count edges from launch until busy drops (bounded).
  task automatic count_busy(output int cyc);
    cyc = 0;
    while (busy === 1'b1 && cyc < 30) begin
      tick();
      cyc++;
    end
  endtask

  task automatic launch(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    start = 1'b1; mdu_op = op; SrcA = a; SrcB = b;
    tick();
    start = 1'b0; mdu_op = 4'd0;
    SrcA = 32'hA5A5_A5A5; SrcB = 32'h5A5A_5A5A;
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; mdu_op = 4'd0; SrcA = 32'b0; SrcB = 32'b0; D_is_md = 1'b0;
    #12;
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_hi", HI, 32'd0);
    check("rst_lo", LO, 32'd0);
    check("rst_result", MDUresult, 32'd0);
    tick();
    reset = 1'b1;
    tick();

    // mult -1 * 2
    D_is_md = 1'b1; start = 1'b1; mdu_op = 4'd1; SrcA = 32'hFFFF_FFFF; SrcB = 32'd2;
    #1 check("stall_on_start", {31'b0, md_stall}, 32'd1);
    D_is_md = 1'b0;
    launch(4'd1, 32'hFFFF_FFFF, 32'd2);
    check("mult_busy_first", {31'b0, busy}, 32'd1);
    count_busy(n);
    check("mult_cycles", n, 32'd5);
    check("mult_hi", HI, 32'hFFFF_FFFF);
    check("mult_lo", LO, 32'hFFFF_FFFE);
    mdu_op = 4'd6; #1 check("mflo", MDUresult, 32'hFFFF_FFFE);
    mdu_op = 4'd5; #1 check("mfhi", MDUresult, 32'hFFFF_FFFF);
    mdu_op = 4'd0; #1 check("mf_none", MDUresult, 32'd0);

    // multu same operands
    launch(4'd2, 32'hFFFF_FFFF, 32'd2);
    count_busy(n);
    check("multu_cycles", n, 32'd5);
    check("multu_hi", HI, 32'h0000_0001);
    check("multu_lo", LO, 32'hFFFF_FFFE);

    // div -7 / 2
    launch(4'd3, 32'hFFFF_FFF9, 32'd2);
    count_busy(n);
    check("div_cycles", n, 32'd10);
    check("div_lo", LO, 32'hFFFF_FFFD);
    check("div_hi", HI, 32'hFFFF_FFFF);

    // div INT_MIN / -1
    launch(4'd3, 32'h8000_0000, 32'hFFFF_FFFF);
    count_busy(n);
    check("divovf_lo", LO, 32'h8000_0000);
    check("divovf_hi", HI, 32'h0000_0000);

    // divu 100 / 7
    launch(4'd4, 32'd100, 32'd7);
    count_busy(n);
    check("divu_lo", LO, 32'd14);
    check("divu_hi", HI, 32'd2);

    // mthi then divu by zero
    mdu_op = 4'd7; SrcA = 32'h0000_1234;
    tick();
    mdu_op = 4'd0;
    check("mthi_hi", HI, 32'h0000_1234);
    check("mthi_lo_kept", LO, 32'd14);
    check("mthi_no_busy", {31'b0, busy}, 32'd0);
    launch(4'd4, 32'd5, 32'd0);
    count_busy(n);
    check("div0_cycles", n, 32'd10);
    check("div0_hi", HI, 32'h0000_1234);
    check("div0_lo", LO, 32'd14);

    // mtlo in idle
    mdu_op = 4'd8; SrcA = 32'h0000_0055;
    tick();
    mdu_op = 4'd0;
    check("mtlo_lo", LO, 32'h0000_0055);
    check("mtlo_hi_kept", HI, 32'h0000_1234);

    // mult 3*4 with ops injected while busy
    D_is_md = 1'b1;
    launch(4'd1, 32'd3, 32'd4);
    check("busy_stall_1", {31'b0, md_stall}, 32'd1);
    mdu_op = 4'd8; SrcA = 32'hDEAD_BEEF;
    tick(); n = 1;
    mdu_op = 4'd0;
    check("busy_stall_2", {31'b0, md_stall}, 32'd1);
    check("busy_mtlo_ignored", LO, 32'h0000_0055);
    start = 1'b1; mdu_op = 4'd3; SrcA = 32'd100; SrcB = 32'd0;
    tick(); n = 2;
    start = 1'b0; mdu_op = 4'd0;
    check("busy_stall_3", {31'b0, md_stall}, 32'd1);
    while (busy === 1'b1 && n < 30) begin
      tick();
      n++;
    end
    check("busy_total_cycles", n, 32'd5);
    check("busy_hi", HI, 32'd0);
    check("busy_lo", LO, 32'd12);
    check("stall_released", {31'b0, md_stall}, 32'd0);
    D_is_md = 1'b0;
    tick();
    check("no_late_div", LO, 32'd12);

    // async reset mid-operation
    mdu_op = 4'd7; SrcA = 32'h0000_0077;
    tick();
    mdu_op = 4'd0;
    launch(4'd1, 32'd3, 32'd5);
    tick();
    reset = 1'b0;
    #1;
    check("arst_busy", {31'b0, busy}, 32'd0);
    check("arst_hi", HI, 32'd0);
    check("arst_lo", LO, 32'd0);
    tick();
    reset = 1'b1;
    for (int i = 0; i < 12; i++) tick();
    check("arst_stay_idle", {31'b0, busy}, 32'd0);
    check("arst_no_late_lo", LO, 32'd0);
    check("arst_no_late_hi", HI, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
